// File: rtl/bus_transfer_ctrl.sv
// bus_transfer_ctrl: command FIFO plus sequencer driving one-hot bus out/in enables.
// Latency: out_en rises one cycle after push; in_en after HOLD_CYCLES more; done one cycle later.
// Backpressure: cmd_ready = !full; optional BUS_ENC_SEL_EN adds registered bus_sel/bus_sel_valid.
module bus_transfer_ctrl #(
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 1
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [4:0]  cmd_src,
    input  logic [4:0]  cmd_dst,
    output logic [19:0] out_en,
    output logic [19:0] in_en,
    output logic        busy,
    output logic        done,
    output logic        err
`ifdef BUS_ENC_SEL_EN
    ,
    output logic [4:0]  bus_sel,
    output logic        bus_sel_valid
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DRIVE, LATCH, DONE} state_t;

    // Command FIFO: {src, dst} per entry, pointers carry an extra wrap bit.
    logic [9:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        push;
    logic        pop;
    logic [4:0]  head_src;
    logic [4:0]  head_dst;
    logic        head_legal;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  src_q;
    logic [4:0]  dst_q;
    logic [4:0]  src_nxt;
    logic [4:0]  dst_nxt;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_nxt;
    logic [19:0] out_nxt;
    logic [19:0] in_nxt;
    logic        done_nxt;
    logic        err_nxt;

    function automatic logic [19:0] onehot(input logic [4:0] code);
        onehot = 20'd1 << code;
    endfunction

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign cmd_ready  = !full;
    assign push       = cmd_valid && cmd_ready;
    assign pop        = (state == IDLE) && !empty;
    assign head_src   = mem[rd_ptr[AW-1:0]][9:5];
    assign head_dst   = mem[rd_ptr[AW-1:0]][4:0];
    assign head_legal = (head_src < 5'd20) && (head_dst < 5'd20);
    assign busy       = (state != IDLE) || !empty;

    // FIFO storage write; contents need no reset since pointers gate reads.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {cmd_src, cmd_dst};
        end
    end

    // FIFO pointer update; push and pop may coincide.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // State register together with the registered enables and pulses.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state  <= IDLE;
            src_q  <= '0;
            dst_q  <= '0;
            cnt_q  <= '0;
            out_en <= '0;
            in_en  <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nxt;
            src_q  <= src_nxt;
            dst_q  <= dst_nxt;
            cnt_q  <= cnt_nxt;
            out_en <= out_nxt;
            in_en  <= in_nxt;
            done   <= done_nxt;
            err    <= err_nxt;
        end
    end

    // Next-state decision; illegal commands are dropped while staying in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!empty && head_legal) state_nxt = DRIVE;
            DRIVE:   if (cnt_q == 4'd0) state_nxt = LATCH;
            LATCH:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs, so every enable leaves a flop.
    always_comb begin
        src_nxt  = src_q;
        dst_nxt  = dst_q;
        cnt_nxt  = cnt_q;
        out_nxt  = '0;
        in_nxt   = '0;
        done_nxt = 1'b0;
        err_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    if (head_legal) begin
                        src_nxt = head_src;
                        dst_nxt = head_dst;
                        cnt_nxt = 4'(HOLD_CYCLES - 1);
                        out_nxt = onehot(head_src);
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            DRIVE: begin
                out_nxt = onehot(src_q);
                if (cnt_q == 4'd0) begin
                    in_nxt = onehot(dst_q);
                end else begin
                    cnt_nxt = cnt_q - 4'd1;
                end
            end
            LATCH:   done_nxt = 1'b1;
            default: ;
        endcase
    end

`ifdef BUS_ENC_SEL_EN
    logic [4:0] sel_nxt;

    // Binary select follows the one-hot enable, zero whenever the bus is idle.
    always_comb begin
        sel_nxt = 5'd0;
        if (state == IDLE && !empty && head_legal) sel_nxt = head_src;
        else if (state == DRIVE)                   sel_nxt = src_q;
    end

    // Select register sits beside out_en so both change on the same edge.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) bus_sel <= 5'd0;
        else       bus_sel <= sel_nxt;
    end

    assign bus_sel_valid = |out_en;
`endif

endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// Directed bench for bus_transfer_ctrl (FIFO_DEPTH=4, HOLD_CYCLES=1).
// Background monitors check enable invariants and log transfers/done/err pulses.
// Optional bus_sel checks compile in when BUS_ENC_SEL_EN is defined.
module tb_bus_transfer_ctrl;

    logic        clock;
    logic        clear;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_src;
    logic [4:0]  cmd_dst;
    logic [19:0] out_en;
    logic [19:0] in_en;
    logic        busy;
    logic        done;
    logic        err;
`ifdef BUS_ENC_SEL_EN
    logic [4:0]  bus_sel;
    logic        bus_sel_valid;
`endif

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    logic [19:0] prev_out = '0;
    int          rises[$];
    logic [39:0] xfers[$];

    bus_transfer_ctrl #(.FIFO_DEPTH(4), .HOLD_CYCLES(1)) dut (
        .clock(clock),
        .clear(clear),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_src(cmd_src),
        .cmd_dst(cmd_dst),
        .out_en(out_en),
        .in_en(in_en),
        .busy(busy),
        .done(done),
        .err(err)
`ifdef BUS_ENC_SEL_EN
        ,
        .bus_sel(bus_sel),
        .bus_sel_valid(bus_sel_valid)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input int src, input int dst);
        cmd_valid = 1'b1;
        cmd_src   = 5'(src);
        cmd_dst   = 5'(dst);
        tick();
        cmd_valid = 1'b0;
    endtask

    function automatic logic [4:0] enc(input logic [19:0] v);
        logic [4:0] r;
        r = 5'd0;
        for (int k = 0; k < 20; k++) if (v[k]) r = 5'(k);
        return r;
    endfunction

    always @(posedge clock) cyc++;

    // Invariants and event logging, sampled mid-cycle.
    always @(negedge clock) begin
        chk("onehot_out", 40'($countones(out_en) <= 1), 40'd1);
        chk("onehot_in", 40'($countones(in_en) <= 1), 40'd1);
        chk("in_implies_out", 40'((in_en == 20'd0) || (out_en != 20'd0)), 40'd1);
`ifdef BUS_ENC_SEL_EN
        chk("bus_sel", 40'(bus_sel), 40'(enc(out_en)));
        chk("bus_sel_valid", 40'(bus_sel_valid), 40'(out_en != 20'd0));
`endif
        if (out_en != 20'd0 && prev_out == 20'd0) rises.push_back(cyc);
        prev_out = out_en;
        if (in_en != 20'd0) xfers.push_back({out_en, in_en});
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
    end

    // Stream n commands src=base+i -> dst=base+i+1 as fast as cmd_ready allows.
    task automatic run_stream(input string tag, input int n, input int base);
        int idx = 0;
        int d0;
        bit saw_full = 1'b0;
        bit fire;
        logic [19:0] eo;
        logic [19:0] ei;
        rises.delete();
        xfers.delete();
        d0 = done_cnt;
        for (int b = 0; b < 300 && (idx < n || done_cnt - d0 < n); b++) begin
            if (idx < n) begin
                cmd_valid = 1'b1;
                cmd_src   = 5'(base + idx);
                cmd_dst   = 5'(base + idx + 1);
            end else begin
                cmd_valid = 1'b0;
            end
            if (cmd_valid && !cmd_ready) saw_full = 1'b1;
            fire = cmd_valid && cmd_ready;
            tick();
            if (fire) idx++;
        end
        cmd_valid = 1'b0;
        tick();
        tick();
        chk({tag, "_backpressure"}, 40'(saw_full), 40'd1);
        chk({tag, "_pushed"}, 40'(idx), 40'(n));
        chk({tag, "_done_count"}, 40'(done_cnt - d0), 40'(n));
        chk({tag, "_xfer_count"}, 40'(xfers.size()), 40'(n));
        chk({tag, "_rise_count"}, 40'(rises.size()), 40'(n));
        chk({tag, "_busy_end"}, 40'(busy), 40'd0);
        for (int i = 0; i < n; i++) begin
            eo = 20'd1 << (base + i);
            ei = 20'd1 << (base + i + 1);
            if (i < xfers.size()) chk({tag, "_order"}, xfers[i], {eo, ei});
            if (i > 0 && i < rises.size()) chk({tag, "_spacing"}, 40'(rises[i] - rises[i-1]), 40'd4);
        end
    endtask

    initial begin
        int d0;
        int e0;
        clear     = 1'b1;
        cmd_valid = 1'b0;
        cmd_src   = 5'd0;
        cmd_dst   = 5'd0;
        #3;
        chk("rst_out_en", 40'(out_en), 40'd0);
        chk("rst_in_en", 40'(in_en), 40'd0);
        chk("rst_busy", 40'(busy), 40'd0);
        chk("rst_done", 40'(done), 40'd0);
        chk("rst_err", 40'(err), 40'd0);
        chk("rst_ready", 40'(cmd_ready), 40'd1);
        tick();
        tick();
        clear = 1'b0;
        tick();

        // Clear asserted in the middle of LATCH for R3 -> R5.
        push(3, 5);
        tick();
        chk("mid_drive_out", 40'(out_en), 40'h8);
        tick();
        chk("mid_latch_in", 40'(in_en), 40'h20);
        d0 = done_cnt;
        clear = 1'b1;
        #1;
        chk("clr_out_en", 40'(out_en), 40'd0);
        chk("clr_in_en", 40'(in_en), 40'd0);
        chk("clr_done", 40'(done), 40'd0);
        chk("clr_busy", 40'(busy), 40'd0);
        chk("clr_ready", 40'(cmd_ready), 40'd1);
        #1;
        clear = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("clr_no_done", 40'(done_cnt - d0), 40'd0);
        chk("clr_idle_out", 40'(out_en), 40'd0);

        // Single MDR -> R2 transfer; cycle k is just after edge k.
        push(18, 2);
        chk("s0_out", 40'(out_en), 40'd0);
        chk("s0_busy", 40'(busy), 40'd1);
        tick();
        chk("s1_out", 40'(out_en), 40'h40000);
        chk("s1_in", 40'(in_en), 40'd0);
        tick();
        chk("s2_out", 40'(out_en), 40'h40000);
        chk("s2_in", 40'(in_en), 40'h4);
        tick();
        chk("s3_out", 40'(out_en), 40'd0);
        chk("s3_in", 40'(in_en), 40'd0);
        chk("s3_done", 40'(done), 40'd1);
        tick();
        chk("s4_done", 40'(done), 40'd0);
        chk("s4_busy", 40'(busy), 40'd0);

        // Back-to-back with backpressure, then a longer stream holding the FIFO full.
        run_stream("b2b", 6, 0);
        run_stream("full", 8, 8);

        // Illegal source code is discarded; the following HI -> LO proceeds.
        e0 = err_cnt;
        d0 = done_cnt;
        push(20, 1);
        push(16, 17);
        chk("ill_err", 40'(err), 40'd1);
        chk("ill_out", 40'(out_en), 40'd0);
        tick();
        chk("ill_err_clr", 40'(err), 40'd0);
        chk("hilo_out", 40'(out_en), 40'h10000);
        tick();
        chk("hilo_in", 40'(in_en), 40'h20000);
        tick();
        chk("hilo_done", 40'(done), 40'd1);
        tick();
        chk("ill_err_count", 40'(err_cnt - e0), 40'd1);
        chk("ill_done_count", 40'(done_cnt - d0), 40'd1);

        // MAR -> R0; bus_sel tracking is checked by the monitor when enabled.
        push(19, 0);
        tick();
        chk("mar_out", 40'(out_en), 40'h80000);
`ifdef BUS_ENC_SEL_EN
        chk("mar_sel", 40'(bus_sel), 40'd19);
        chk("mar_sel_valid", 40'(bus_sel_valid), 40'd1);
`endif
        tick();
        chk("mar_in", 40'(in_en), 40'h1);
        tick();
        chk("mar_done", 40'(done), 40'd1);
`ifdef BUS_ENC_SEL_EN
        chk("mar_sel_off", 40'(bus_sel), 40'd0);
        chk("mar_sel_valid_off", 40'(bus_sel_valid), 40'd0);
`endif
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
